// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 16x-oversampled UART receiver that turns the serial line into
// {bi,fe,pe,data} words with one-cycle done/error strobes.
module uart_rx_deframer #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [7:0]  dll,
    input  logic [7:0]  dlh,
    input  logic        urrst,
    input  logic [1:0]  wls,
    input  logic        pen,
    input  logic        eps,
    input  logic        sp,
    input  logic        loop,
    input  logic        loop_txd,
    input  logic        uart_rxd,
    output logic [10:0] rbr,
    output logic        receive_done,
    output logic        error_check,
    output logic        parity_error,
    output logic        frame_error,
    output logic        uart_break,
    output logic        rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);

    state_t                 state_q, state_d;
    logic [15:0]            div_cnt_q, div_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             scnt_q, scnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             data_q, data_d;
    logic                   pe_q, pe_d, par_q, par_d;
    logic [10:0]            rbr_q, rbr_d;
    logic                   done_q, done_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
    logic [15:0]            div;
    logic                   tick, rx_s, sample, exp_par, fe, bi, pe_out;
    logic [2:0]             last_bit;

    assign div      = {dlh, dll};
    assign tick     = (div != 16'd0) && (div_cnt_q == 16'd0);
    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign sample   = tick && (scnt_q == LAST);
    assign last_bit = 3'd4 + {1'b0, wls};
    assign exp_par  = sp ? ~eps : (eps ? ^data_q : ~^data_q);
    assign fe       = ~rx_s;
    assign bi       = fe && (data_q == 8'd0) && (!par_q || !pen);
    assign pe_out   = pe_q && pen;

    always_comb begin
        div_cnt_d = tick ? div - 16'd1 : (div_cnt_q != 16'd0 ? div_cnt_q - 16'd1 : div_cnt_q);
        sync_d    = {sync_q[SYNC_STAGES-2:0], loop ? loop_txd : uart_rxd};
        state_d   = state_q;
        scnt_d    = tick ? scnt_q + 4'd1 : scnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        pe_d      = pe_q;
        par_d     = par_q;
        rbr_d     = rbr_q;
        done_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        brk_d     = 1'b0;
        case (state_q)
            IDLE: begin
                scnt_d = 4'd0;
                if (!rx_s) state_d = START;
            end
            START: if (tick && scnt_q == MID) begin
                scnt_d  = 4'd0;
                state_d = rx_s ? IDLE : DATA;
                bit_d   = 3'd0;
                data_d  = 8'd0;
                pe_d    = 1'b0;
                par_d   = 1'b0;
            end
            DATA: if (sample) begin
                scnt_d         = 4'd0;
                data_d[bit_q]  = rx_s;
                bit_d          = bit_q + 3'd1;
                if (bit_q == last_bit) state_d = pen ? PARITY : STOP;
            end
            PARITY: if (sample) begin
                scnt_d  = 4'd0;
                par_d   = rx_s;
                pe_d    = rx_s != exp_par;
                state_d = STOP;
            end
            STOP: if (sample) begin
                scnt_d  = 4'd0;
                rbr_d   = {bi, fe, pe_out, data_q};
                done_d  = 1'b1;
                perr_d  = pe_out;
                ferr_d  = fe;
                brk_d   = bi;
                // a low stop bit parks the FSM until the line idles, so a held break is one frame
                state_d = rx_s ? IDLE : BRK_WAIT;
            end
            BRK_WAIT: begin
                scnt_d = 4'd0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!urrst) begin
            state_d   = IDLE;
            scnt_d    = 4'd0;
            div_cnt_d = 16'd0;
            bit_d     = 3'd0;
            data_d    = 8'd0;
            rbr_d     = 11'd0;
            done_d    = 1'b0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            brk_d     = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            div_cnt_q <= 16'd0;
            sync_q    <= '1;
            scnt_q    <= 4'd0;
            bit_q     <= 3'd0;
            data_q    <= 8'd0;
            pe_q      <= 1'b0;
            par_q     <= 1'b0;
            rbr_q     <= 11'd0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            sync_q    <= sync_d;
            scnt_q    <= scnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            pe_q      <= pe_d;
            par_q     <= par_d;
            rbr_q     <= rbr_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
        end
    end

    assign rbr          = rbr_q;
    assign receive_done = done_q;
    assign error_check  = done_q;
    assign parity_error = perr_q;
    assign frame_error  = ferr_q;
    assign uart_break   = brk_q;
    assign rx_busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed frames on uart_rxd/loop_txd with hand-computed rbr words,
// latency window, break, glitch, loopback and receiver-reset cases.
module tb_uart_rx_deframer;
    logic        pclk = 1'b0, presetn = 1'b0;
    logic [7:0]  dll = 8'd1, dlh = 8'd0;
    logic        urrst = 1'b0;
    logic [1:0]  wls = 2'b11;
    logic        pen = 1'b0, eps = 1'b0, sp = 1'b0, loop = 1'b0, loop_txd = 1'b1, uart_rxd = 1'b1;
    logic [10:0] rbr;
    logic        receive_done, error_check, parity_error, frame_error, uart_break, rx_busy;

    int          n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, done_cyc = 0, d0 = 0, s0 = 0;
    logic [10:0] cap_rbr = '0;
    logic        cap_ec = 1'b0, cap_pe = 1'b0, cap_fe = 1'b0, cap_bi = 1'b0;

    uart_rx_deframer dut (
        .pclk(pclk), .presetn(presetn), .dll(dll), .dlh(dlh), .urrst(urrst), .wls(wls),
        .pen(pen), .eps(eps), .sp(sp), .loop(loop), .loop_txd(loop_txd), .uart_rxd(uart_rxd),
        .rbr(rbr), .receive_done(receive_done), .error_check(error_check),
        .parity_error(parity_error), .frame_error(frame_error), .uart_break(uart_break),
        .rx_busy(rx_busy)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) if (receive_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        cap_rbr  <= rbr;
        cap_ec   <= error_check;
        cap_pe   <= parity_error;
        cap_fe   <= frame_error;
        cap_bi   <= uart_break;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tx_bit(input logic v, input int n);
        if (loop) loop_txd = v;
        else uart_rxd = v;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int nbits, input bit par_en, input logic par,
                        input int bc, input int abort_at);
        tx_bit(1'b0, bc);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) urrst = 1'b0;
            tx_bit(d[i], bc);
        end
        if (par_en) tx_bit(par, bc);
        tx_bit(1'b1, bc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        idle(5);
        presetn = 1'b1;
        idle(2);
        check("rst_rbr", rbr, 11'h000);
        check("rst_strobes", {receive_done, error_check, parity_error, frame_error, uart_break}, 5'b0);
        check("rst_busy", rx_busy, 1'b0);
        urrst = 1'b1;
        idle(4);

        // 8N1 0xA5, div=1
        d0 = done_cnt; s0 = cyc;
        send(8'hA5, 8, 1'b0, 1'b0, 16, 99);
        idle(32);
        check("a5_count", done_cnt - d0, 1);
        check("a5_rbr", cap_rbr, 11'h0A5);
        check("a5_ec", cap_ec, 1'b1);
        check("a5_flags", {cap_pe, cap_fe, cap_bi}, 3'b000);
        check("a5_latency", (done_cyc - s0 >= 152) && (done_cyc - s0 <= 156), 1'b1);
        check("a5_busy", rx_busy, 1'b0);

        // 7E1, div=3: 0x35 has four ones, so even parity bit is 0
        dll = 8'd3; wls = 2'b10; pen = 1'b1; eps = 1'b1;
        idle(8);
        d0 = done_cnt;
        send(8'h35, 7, 1'b1, 1'b1, 48, 99);
        idle(96);
        check("par_bad_count", done_cnt - d0, 1);
        check("par_bad_rbr", cap_rbr, 11'h135);
        check("par_bad_pe", cap_pe, 1'b1);
        check("par_bad_ec", cap_ec, 1'b1);
        send(8'h35, 7, 1'b1, 1'b0, 48, 99);
        idle(96);
        check("par_ok_rbr", cap_rbr, 11'h035);
        check("par_ok_pe", cap_pe, 1'b0);

        // 20-bit-time break, div=1 8N1
        dll = 8'd1; wls = 2'b11; pen = 1'b0; eps = 1'b0;
        idle(8);
        d0 = done_cnt;
        uart_rxd = 1'b0;
        idle(320);
        check("brk_count", done_cnt - d0, 1);
        check("brk_rbr", cap_rbr, 11'h600);
        check("brk_flags", {cap_bi, cap_fe, cap_pe}, 3'b110);
        check("brk_wait_busy", rx_busy, 1'b1);
        uart_rxd = 1'b1;
        idle(40);
        check("brk_release_busy", rx_busy, 1'b0);
        check("brk_no_second", done_cnt - d0, 1);

        // 4-cycle glitch: START must abort at the mid-bit sample
        d0 = done_cnt;
        uart_rxd = 1'b0;
        idle(4);
        check("glitch_start_busy", rx_busy, 1'b1);
        uart_rxd = 1'b1;
        idle(40);
        check("glitch_busy", rx_busy, 1'b0);
        check("glitch_no_done", done_cnt - d0, 0);

        // loopback with the external line held low
        loop_txd = 1'b1; loop = 1'b1;
        idle(2);
        uart_rxd = 1'b0;
        d0 = done_cnt;
        send(8'h3C, 8, 1'b0, 1'b0, 16, 99);
        idle(32);
        check("loop_count", done_cnt - d0, 1);
        check("loop_rbr", cap_rbr, 11'h03C);
        uart_rxd = 1'b1;
        idle(4);
        loop = 1'b0;
        idle(8);

        // receiver reset after three data bits
        d0 = done_cnt;
        send(8'h5A, 8, 1'b0, 1'b0, 16, 3);
        idle(8);
        check("urrst_no_done", done_cnt - d0, 0);
        check("urrst_rbr", rbr, 11'h000);
        check("urrst_busy", rx_busy, 1'b0);
        urrst = 1'b1;
        idle(16);
        send(8'h5A, 8, 1'b0, 1'b0, 16, 99);
        idle(32);
        check("rearm_count", done_cnt - d0, 1);
        check("rearm_rbr", cap_rbr, 11'h05A);

        // div=0 freezes the FSM after the start edge
        dll = 8'd0;
        idle(4);
        d0 = done_cnt;
        send(8'h5A, 8, 1'b0, 1'b0, 16, 99);
        idle(32);
        check("div0_no_done", done_cnt - d0, 0);
        check("div0_frozen_busy", rx_busy, 1'b1);
        urrst = 1'b0;
        idle(2);
        check("div0_urrst_busy", rx_busy, 1'b0);
        urrst = 1'b1; dll = 8'd1;
        idle(8);
        send(8'hC3, 8, 1'b0, 1'b0, 16, 99);
        idle(32);
        check("recover_count", done_cnt - d0, 1);
        check("recover_rbr", cap_rbr, 11'h0C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
